priority_encoder_stream: RTL and testbench
==========================================

PRIORITY_ENCODER_STREAM -- requirements
Module: priority_encoder_stream

Interface
REQ-001 Parameter N, default 16: width of the request vector, legal range 2..256.
REQ-002 Parameter LSB_FIRST, default 0: 0 emits indices highest-first, 1 emits indices lowest-first.
REQ-003 Derived constant W = $clog2(N): index width, not user-overridable.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-006 in_valid  input  1  request vector on in_vec is valid.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in_vec  input  N  one-hot-or-multi-hot request vector.
REQ-009 out_valid  output  1  out_idx/out_last/out_zero are valid.
REQ-010 out_ready  input  1  consumer accepts the current beat.
REQ-011 out_idx  output  W  binary index of the selected set bit.
REQ-012 out_last  output  1  current beat is the final beat for the accepted vector.
REQ-013 out_zero  output  1  current beat reports an all-zero vector (see Configuration).

Function
REQ-014 The block SHALL have two states: IDLE and SCAN, with a remaining-bits register rem[N-1:0].
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In IDLE, on in_valid=1 with in_vec!=0, the block SHALL load rem<=in_vec and enter SCAN; out_valid SHALL rise on the next cycle (latency 1).
REQ-017 In SCAN, in_ready SHALL be 0, out_valid SHALL be 1, and out_idx SHALL be the index of the highest set bit of rem (LSB_FIRST=0) or the lowest (LSB_FIRST=1).
REQ-018 out_last SHALL be 1 exactly when rem has a single set bit.
REQ-019 On out_valid&&out_ready, the selected bit SHALL be cleared from rem; if out_last=1, the state SHALL return to IDLE.
REQ-020 With out_ready held at 1, the block SHALL emit one index per cycle: popcount(in_vec) beats back-to-back.
REQ-021 While out_ready=0, out_idx, out_last, out_zero and rem SHALL be held stable.
REQ-022 A new vector SHALL NOT be accepted in the cycle the last beat is consumed; in_ready returns to 1 on the following cycle.
REQ-023 in_vec changes while in SCAN SHALL have no effect.
REQ-024 out_idx SHALL be 0 whenever out_valid=0.

Reset
REQ-025 While rst_n=0 at a clock edge: state<=IDLE, rem<=0, out_valid=0, out_idx=0, out_last=0, out_zero=0.
REQ-026 in_ready SHALL be 0 during the cycles rst_n=0 is sampled and 1 from the first cycle after rst_n is sampled high.
REQ-027 Reset asserted mid-SCAN SHALL discard all remaining bits with no further output beats.

Configuration
REQ-028 Macro PENC_ZERO_REPORT_EN defined: an accepted all-zero vector SHALL produce exactly one beat with out_zero=1, out_idx=0, out_last=1, under the same handshake.
REQ-029 Macro PENC_ZERO_REPORT_EN undefined: an accepted all-zero vector SHALL be consumed silently (state stays IDLE, no beat), and out_zero SHALL be tied to 0.

Structure
REQ-030 Package penc_pkg SHALL hold the state enumeration (IDLE, SCAN) and the W-derivation helper.
REQ-031 The selection logic SHALL be a combinational sub-module penc_pick (parameters N, LSB_FIRST; in: vector; out: index, single-bit flag, any-bit flag).

Verification
REQ-032 N=16, LSB_FIRST=0, in_vec=16'h8421, out_ready=1 -> idx 15,10,5,0 on four consecutive cycles, out_last only on idx 0.
REQ-033 N=16, LSB_FIRST=1, in_vec=16'h0006, out_ready toggled 0/1 -> idx 1 then 2, values held during stalls, out_last on idx 2.
REQ-034 in_vec=16'h0000 -> with PENC_ZERO_REPORT_EN: one beat out_zero=1, idx 0, last=1; without: no beat, in_ready stays 1.
REQ-035 in_vec=16'hFFFF, rst_n=0 after 5 beats -> out_valid=0 next cycle, in_ready=1 one cycle after rst_n is sampled high, no residual beats.
REQ-036 Back-to-back vectors 16'h0001 then 16'h0100 with in_valid held -> second vector accepted one cycle after the first beat is consumed; outputs idx 0 then idx 8.
REQ-037 N=5, LSB_FIRST=0, in_vec=5'b10011 -> W=3, idx 4,1,0.

Source files
------------

// File: rtl/penc_pkg.sv
// Shared types and helpers for the streaming priority encoder.
package penc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } penc_state_e;

  // Index width for an N-bit request vector; never below one bit.
  function automatic int penc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/penc_pick.sv
// Combinational selector: picks the highest (or lowest) set bit of a vector
// and reports whether the vector holds exactly one set bit or any set bit.
module penc_pick
  import penc_pkg::*;
#(
  parameter int N         = 16,
  parameter bit LSB_FIRST = 1'b0,
  localparam int W        = penc_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         single,
  output logic         any
);

  // Scan order is chosen so the last hit wins: ascending for highest-first,
  // descending for lowest-first.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  always_comb begin
    any    = |vec;
    single = any && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder: accepts a request vector and emits the index
// of each set bit, one beat per accepted handshake.
// Optional feature macro: PENC_ZERO_REPORT_EN (report all-zero vectors as a
// single out_zero beat instead of dropping them).
//
// state | meaning
// IDLE  | waiting for a request vector, in_ready high once out of reset
// SCAN  | emitting indices from rem until the last bit is consumed
module priority_encoder_stream
  import penc_pkg::*;
#(
  parameter int N         = 16,
  parameter bit LSB_FIRST = 1'b0,
  localparam int W        = penc_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_zero
);

  penc_state_e  state, state_nxt;
  logic [N-1:0] rem, rem_nxt;
  logic         ready_q;
  logic         zero_q;
  logic [W-1:0] pick_idx;
  logic         pick_single;
  logic         pick_any;

  penc_pick #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_pick (
    .vec    (rem),
    .idx    (pick_idx),
    .single (pick_single),
    .any    (pick_any)
  );

`ifdef PENC_ZERO_REPORT_EN
  logic zero_nxt;

  // Remembers that the pending beat reports an all-zero vector.
  always_ff @(posedge clk) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_nxt;
  end
`else
  assign zero_q = 1'b0;
`endif

  // State, remaining bits, and a ready flag that stays low until the first
  // cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      ready_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs; outputs depend only on registered
  // state so they hold steady while the consumer stalls.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
`ifdef PENC_ZERO_REPORT_EN
    zero_nxt  = zero_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ready_q;
        if (in_valid && ready_q) begin
          if (in_vec != '0) begin
            rem_nxt   = in_vec;
            state_nxt = SCAN;
          end
`ifdef PENC_ZERO_REPORT_EN
          else begin
            zero_nxt  = 1'b1;
            state_nxt = SCAN;
          end
`endif
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        if (zero_q) begin
          out_zero = 1'b1;
          out_last = 1'b1;
        end else begin
          out_idx  = pick_any ? pick_idx : '0;
          out_last = pick_single;
        end
        if (out_ready) begin
          rem_nxt = rem & ~(N'(1) << pick_idx);
          if (out_last) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
`ifdef PENC_ZERO_REPORT_EN
            zero_nxt  = 1'b0;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Directed bench for priority_encoder_stream: three instances cover the
// default build, lowest-first ordering with stalls, and a non-power-of-2 width.
module tb_priority_encoder_stream;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: N=16, highest-first
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_out_zero;
  logic [15:0] a_in_vec;
  logic [3:0]  a_out_idx;

  // Instance B: N=16, lowest-first
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_zero;
  logic [15:0] b_in_vec;
  logic [3:0]  b_out_idx;

  // Instance C: N=5, highest-first
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_out_zero;
  logic [4:0]  c_in_vec;
  logic [2:0]  c_out_idx;

  priority_encoder_stream #(.N(16), .LSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_vec(a_in_vec), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_idx(a_out_idx), .out_last(a_out_last), .out_zero(a_out_zero));

  priority_encoder_stream #(.N(16), .LSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_in_vec), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_zero(b_out_zero));

  priority_encoder_stream #(.N(5), .LSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_vec(c_in_vec), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_idx(c_out_idx), .out_last(c_out_last), .out_zero(c_out_zero));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks an instance-A beat and lets it be consumed (out_ready held high).
  task automatic a_beat(input string tag, input int idx, input bit last);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_idx"},   32'(a_out_idx),   32'(idx));
    chk({tag, "_last"},  32'(a_out_last),  32'(last));
    chk({tag, "_zero"},  32'(a_out_zero),  32'd0);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_vec = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_vec = '0; c_out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_in_ready",  32'(a_in_ready),  32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_idx",   32'(a_out_idx),   32'd0);
    chk("rst_out_last",  32'(a_out_last),  32'd0);
    chk("rst_out_zero",  32'(a_out_zero),  32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // 8421 highest-first, full throughput
    a_in_valid = 1'b1; a_in_vec = 16'h8421;
    chk("p8421_idle_valid", 32'(a_out_valid), 32'd0);
    tick();
    a_in_valid = 1'b0; a_in_vec = 16'hFFFF;
    chk("p8421_busy_ready", 32'(a_in_ready), 32'd0);
    a_beat("p8421_b0", 15, 1'b0);
    a_beat("p8421_b1", 10, 1'b0);
    a_beat("p8421_b2", 5,  1'b0);
    a_beat("p8421_b3", 0,  1'b1);
    chk("p8421_done_valid", 32'(a_out_valid), 32'd0);
    chk("p8421_done_idx",   32'(a_out_idx),   32'd0);
    chk("p8421_done_ready", 32'(a_in_ready),  32'd1);

    // All-zero vector
    a_in_valid = 1'b1; a_in_vec = 16'h0000;
    chk("zero_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
`ifdef PENC_ZERO_REPORT_EN
    chk("zero_valid", 32'(a_out_valid), 32'd1);
    chk("zero_flag",  32'(a_out_zero),  32'd1);
    chk("zero_idx",   32'(a_out_idx),   32'd0);
    chk("zero_last",  32'(a_out_last),  32'd1);
    tick();
    chk("zero_after_valid", 32'(a_out_valid), 32'd0);
    chk("zero_after_ready", 32'(a_in_ready),  32'd1);
`else
    chk("zero_valid", 32'(a_out_valid), 32'd0);
    chk("zero_flag",  32'(a_out_zero),  32'd0);
    chk("zero_ready", 32'(a_in_ready),  32'd1);
    tick();
    chk("zero_after_valid", 32'(a_out_valid), 32'd0);
`endif

    // Back-to-back vectors with in_valid held; in_vec change during SCAN ignored
    a_in_valid = 1'b1; a_in_vec = 16'h0001;
    tick();
    a_in_vec = 16'h0100;
    chk("b2b_first_ready", 32'(a_in_ready), 32'd0);
    a_beat("b2b_first", 0, 1'b1);
    chk("b2b_gap_valid", 32'(a_out_valid), 32'd0);
    chk("b2b_gap_ready", 32'(a_in_ready),  32'd1);
    tick();
    a_in_valid = 1'b0;
    a_beat("b2b_second", 8, 1'b1);
    chk("b2b_end_valid", 32'(a_out_valid), 32'd0);

    // Lowest-first with stalls on instance B
    b_in_valid = 1'b1; b_in_vec = 16'h0006;
    tick();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    chk("lsb_s0_valid", 32'(b_out_valid), 32'd1);
    chk("lsb_s0_idx",   32'(b_out_idx),   32'd1);
    chk("lsb_s0_last",  32'(b_out_last),  32'd0);
    tick();
    chk("lsb_s1_idx",   32'(b_out_idx),   32'd1);
    chk("lsb_s1_last",  32'(b_out_last),  32'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("lsb_s2_idx",   32'(b_out_idx),   32'd2);
    chk("lsb_s2_last",  32'(b_out_last),  32'd1);
    tick();
    chk("lsb_s3_valid", 32'(b_out_valid), 32'd1);
    chk("lsb_s3_idx",   32'(b_out_idx),   32'd2);
    chk("lsb_s3_last",  32'(b_out_last),  32'd1);
    b_out_ready = 1'b1;
    tick();
    chk("lsb_done_valid", 32'(b_out_valid), 32'd0);
    chk("lsb_done_ready", 32'(b_in_ready),  32'd1);

    // N=5 highest-first on instance C
    c_in_valid = 1'b1; c_in_vec = 5'b10011;
    tick();
    c_in_valid = 1'b0;
    chk("n5_b0_idx",  32'(c_out_idx),  32'd4);
    chk("n5_b0_last", 32'(c_out_last), 32'd0);
    tick();
    chk("n5_b1_idx",  32'(c_out_idx),  32'd1);
    chk("n5_b1_last", 32'(c_out_last), 32'd0);
    tick();
    chk("n5_b2_idx",  32'(c_out_idx),  32'd0);
    chk("n5_b2_last", 32'(c_out_last), 32'd1);
    tick();
    chk("n5_done_valid", 32'(c_out_valid), 32'd0);

    // Reset mid-scan of FFFF after five consumed beats
    a_in_valid = 1'b1; a_in_vec = 16'hFFFF;
    tick();
    a_in_valid = 1'b0;
    a_beat("ffff_b0", 15, 1'b0);
    a_beat("ffff_b1", 14, 1'b0);
    a_beat("ffff_b2", 13, 1'b0);
    a_beat("ffff_b3", 12, 1'b0);
    a_beat("ffff_b4", 11, 1'b0);
    chk("ffff_b5_idx", 32'(a_out_idx), 32'd10);
    rst_n = 1'b0;
    tick();
    chk("ffff_rst_valid", 32'(a_out_valid), 32'd0);
    chk("ffff_rst_ready", 32'(a_in_ready),  32'd0);
    chk("ffff_rst_idx",   32'(a_out_idx),   32'd0);
    rst_n = 1'b1;
    tick();
    chk("ffff_rel_ready", 32'(a_in_ready),  32'd1);
    chk("ffff_rel_valid", 32'(a_out_valid), 32'd0);
    tick();
    chk("ffff_residual_valid", 32'(a_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
